// File: rtl/uart_pkg.sv
// Shared UART framing definitions: header byte, packet-parser states and timeout sizing.
package uart_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hAA;

  typedef enum logic [2:0] {
    WAIT_HEADER,
    GET_LEN,
    GET_PAYLOAD,
    GET_CHK,
    DRAIN
  } pkt_state_t;

  // One byte-time is 10 bit-times (start + 8 data + stop).
  function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                 input int unsigned baud,
                                                 input int unsigned nbytes);
    return nbytes * 10 * (clk_hz / baud);
  endfunction

endpackage

// File: rtl/uart_packet_rx.sv
// Frame parser behind the UART receiver: AA, LEN, payload, XOR checksum.
// A good payload is buffered and replayed as a valid/ready byte stream with a last marker.
module uart_packet_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 25_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int MAX_LEN       = 64,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_last,
  input  logic       i_ready,
  output logic       o_pkt_ok,
  output logic       o_err_chk,
  output logic       o_err_len,
  output logic       o_err_timeout,
  output logic       o_overrun
);

  localparam int unsigned TO_CYC = timeout_cycles(CLK_FREQ_HZ, BAUD_RATE, TIMEOUT_BYTES);
  localparam int          TW     = $clog2(TO_CYC + 1);
  localparam int          PW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned MAXL_U = MAX_LEN;

  pkt_state_t    state, state_nxt;
  logic [7:0]    len, chk;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] to_cnt;
  logic [7:0]    pld_mem [MAX_LEN];

  logic len_ok, wr_last, rd_last, to_hit, in_frame, xfer, chk_match;
  logic pkt_ok_nxt, err_chk_nxt, err_len_nxt, err_to_nxt, ovr_nxt;

  assign in_frame  = (state == GET_LEN) || (state == GET_PAYLOAD) || (state == GET_CHK);
  assign len_ok    = (i_rx_byte != 8'd0) && (32'(i_rx_byte) <= MAXL_U);
  assign wr_last   = (32'(wr_ptr) == 32'(len) - 32'd1);
  assign rd_last   = (32'(rd_ptr) == 32'(len) - 32'd1);
  assign chk_match = (i_rx_byte == chk);
  assign to_hit    = in_frame && !i_rx_dv && (to_cnt == TW'(TO_CYC - 1));
  assign xfer      = o_valid && i_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_HEADER;
    else          state <= state_nxt;
  end

  // Next-state logic; a byte arriving on the expiry cycle takes priority over the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_HEADER: if (i_rx_dv && i_rx_byte == HEADER_BYTE) state_nxt = GET_LEN;
      GET_LEN: begin
        if (i_rx_dv)     state_nxt = len_ok ? GET_PAYLOAD : WAIT_HEADER;
        else if (to_hit) state_nxt = WAIT_HEADER;
      end
      GET_PAYLOAD: begin
        if (i_rx_dv)     state_nxt = wr_last ? GET_CHK : GET_PAYLOAD;
        else if (to_hit) state_nxt = WAIT_HEADER;
      end
      GET_CHK: begin
        if (i_rx_dv)     state_nxt = chk_match ? DRAIN : WAIT_HEADER;
        else if (to_hit) state_nxt = WAIT_HEADER;
      end
      DRAIN:   if (xfer && rd_last) state_nxt = WAIT_HEADER;
      default: state_nxt = WAIT_HEADER;
    endcase
  end

  // Output logic: stream side is combinational off the state, pulses are staged for registering
  always_comb begin
    o_valid     = (state == DRAIN);
    o_data      = o_valid ? pld_mem[rd_ptr] : 8'h00;
    o_last      = o_valid && rd_last;
    pkt_ok_nxt  = (state == GET_CHK) && i_rx_dv && chk_match;
    err_chk_nxt = (state == GET_CHK) && i_rx_dv && !chk_match;
    err_len_nxt = (state == GET_LEN) && i_rx_dv && !len_ok;
    err_to_nxt  = to_hit;
    ovr_nxt     = (state == DRAIN) && i_rx_dv;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_pkt_ok      <= 1'b0;
      o_err_chk     <= 1'b0;
      o_err_len     <= 1'b0;
      o_err_timeout <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_pkt_ok      <= pkt_ok_nxt;
      o_err_chk     <= err_chk_nxt;
      o_err_len     <= err_len_nxt;
      o_err_timeout <= err_to_nxt;
      o_overrun     <= ovr_nxt;
    end
  end

  // to_cnt holds cycles elapsed since the last strobe, so the strobe cycle counts as zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len    <= 8'd0;
      chk    <= 8'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      to_cnt <= '0;
    end else begin
      if (state == GET_LEN && i_rx_dv && len_ok) begin
        len    <= i_rx_byte;
        chk    <= i_rx_byte;
        wr_ptr <= '0;
      end
      if (state == GET_PAYLOAD && i_rx_dv) begin
        chk <= chk ^ i_rx_byte;
        if (!wr_last) wr_ptr <= wr_ptr + 1'b1;
      end
      if (pkt_ok_nxt) rd_ptr <= '0;
      else if (xfer && !rd_last) rd_ptr <= rd_ptr + 1'b1;

      if (!in_frame || to_hit) to_cnt <= '0;
      else if (i_rx_dv)        to_cnt <= TW'(1);
      else                     to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == GET_PAYLOAD && i_rx_dv) pld_mem[wr_ptr] <= i_rx_byte;
  end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Randomized and directed bench for uart_packet_rx against a queue-based frame parser model.
module tb_uart_packet_rx;
  import uart_pkg::*;

  localparam int MAXL = 64;
  localparam int EV_OK = 1, EV_CHK = 2, EV_LEN = 3, EV_TO = 4;

  logic       clk = 1'b0, reset_n = 1'b0, i_rx_dv = 1'b0, i_ready = 1'b0;
  logic [7:0] i_rx_byte = 8'h00;
  logic [7:0] o_data;
  logic       o_valid, o_last, o_pkt_ok, o_err_chk, o_err_len, o_err_timeout, o_overrun;

  uart_packet_rx #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .MAX_LEN(MAXL), .TIMEOUT_BYTES(4)) dut (
    .clk(clk), .reset_n(reset_n), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
    .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready),
    .o_pkt_ok(o_pkt_ok), .o_err_chk(o_err_chk), .o_err_len(o_err_len),
    .o_err_timeout(o_err_timeout), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  byte unsigned stream[$];
  int          exp_ev[$], obs_ev[$];
  logic [8:0]  exp_dat[$], obs_dat[$];
  int          exp_ovr = 0, obs_ovr = 0;
  bit          rand_rdy = 0;
  logic        prev_stall = 1'b0;
  logic [9:0]  prev_out = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: records pulses and transfers; checks the stream holds during stalls
  always @(negedge clk) begin
    if (prev_stall) chk("hold", {22'd0, o_valid, o_last, o_data}, {22'd0, prev_out});
    if (o_pkt_ok)      obs_ev.push_back(EV_OK);
    if (o_err_chk)     obs_ev.push_back(EV_CHK);
    if (o_err_len)     obs_ev.push_back(EV_LEN);
    if (o_err_timeout) obs_ev.push_back(EV_TO);
    if (o_overrun)     obs_ovr++;
    if (o_valid && i_ready) obs_dat.push_back({o_last, o_data});
    prev_stall = o_valid && !i_ready && reset_n;
    prev_out   = {o_valid, o_last, o_data};
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) i_ready = 1'($urandom % 2);
  end

  // Reference: parse the logged byte stream into expected events and payload bytes
  task automatic model_parse();
    byte unsigned q[$];
    q = stream;
    stream.delete();
    while (q.size() > 0) begin
      byte unsigned b, len, x, c;
      byte unsigned pl[$];
      logic [8:0] d;
      b = q.pop_front();
      if (b != 8'hAA) continue;
      if (q.size() == 0) break;
      len = q.pop_front();
      if (len == 0 || len > MAXL) begin exp_ev.push_back(EV_LEN); continue; end
      if (q.size() < int'(len) + 1) break;
      x = len;
      for (int i = 0; i < int'(len); i++) begin pl.push_back(q.pop_front()); x ^= pl[i]; end
      c = q.pop_front();
      if (c == x) begin
        exp_ev.push_back(EV_OK);
        for (int i = 0; i < int'(len); i++) begin
          d = {1'(i == int'(len) - 1), pl[i]};
          exp_dat.push_back(d);
        end
      end else exp_ev.push_back(EV_CHK);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle, input bit log_it = 1'b1);
    repeat (idle) @(posedge clk);
    #1 i_rx_dv = 1'b1; i_rx_byte = b;
    if (log_it) stream.push_back(b);
    @(posedge clk); #1 i_rx_dv = 1'b0;
  endtask

  task automatic send_frame(input byte unsigned pl[$], input bit bad, input int max_idle);
    byte unsigned x;
    x = byte'(pl.size());
    send_byte(8'hAA, $urandom % (max_idle + 1));
    send_byte(x, $urandom % (max_idle + 1));
    foreach (pl[i]) begin send_byte(pl[i], $urandom % (max_idle + 1)); x ^= pl[i]; end
    if (bad) x ^= byte'(1 + $urandom % 255);
    send_byte(x, $urandom % (max_idle + 1));
  endtask

  task automatic rand_payload(input int n, output byte unsigned pl[$]);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(byte'($urandom));
  endtask

  task automatic wait_drain();
    int t = 0;
    while (o_valid && t < 3000) begin @(posedge clk); #1; t++; end
    if (t >= 3000) chk("drain_bound", {31'd0, o_valid}, 32'd0);
  endtask

  task automatic compare(input string tag);
    repeat (3) @(posedge clk); #1;
    model_parse();
    chk({tag, "_nev"}, obs_ev.size(), exp_ev.size());
    for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++) chk({tag, "_ev"}, obs_ev[i], exp_ev[i]);
    chk({tag, "_ndat"}, obs_dat.size(), exp_dat.size());
    for (int i = 0; i < obs_dat.size() && i < exp_dat.size(); i++)
      chk({tag, "_dat"}, {23'd0, obs_dat[i]}, {23'd0, exp_dat[i]});
    chk({tag, "_ovr"}, obs_ovr, exp_ovr);
    obs_ev.delete(); exp_ev.delete(); obs_dat.delete(); exp_dat.delete();
    obs_ovr = 0; exp_ovr = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned pl[$];
    byte unsigned bp[3];
    bit pat[6];
    int ntx;
    bp  = '{8'hA1, 8'hB2, 8'hC3};
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk); #1;
    chk("rst_out", {17'd0, o_data, o_valid, o_last, o_pkt_ok, o_err_chk, o_err_len, o_err_timeout, o_overrun}, 32'd0);
    chk("rst_state", 32'(dut.state), 32'(WAIT_HEADER));
    reset_n = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;

    // Good frame, exact latency and ordering
    send_byte(8'hAA, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h03, 0);
    @(negedge clk); chk("lat_ok", {31'd0, o_pkt_ok}, 32'd1); chk("lat_b0", {22'd0, o_valid, o_last, o_data}, {22'd0, 2'b10, 8'h11});
    @(negedge clk); chk("lat_ok_pulse", {31'd0, o_pkt_ok}, 32'd0); chk("lat_b1", {22'd0, o_valid, o_last, o_data}, {22'd0, 2'b10, 8'h22});
    @(negedge clk); chk("lat_b2", {22'd0, o_valid, o_last, o_data}, {22'd0, 2'b11, 8'h33});
    @(negedge clk); chk("lat_end", {31'd0, o_valid}, 32'd0);
    @(posedge clk); #1;
    compare("good3");

    // Bad checksum then a 1-byte frame
    send_byte(8'hAA, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h04, 0);
    @(negedge clk); chk("badchk_novalid", {31'd0, o_valid}, 32'd0);
    @(posedge clk); #1;
    compare("badchk");
    send_byte(8'hAA, 1); send_byte(8'h01, 1); send_byte(8'h5A, 1); send_byte(8'h5B, 1);
    wait_drain(); compare("after_badchk");

    // Length errors, each followed by a good frame; then LEN = MAX_LEN
    send_byte(8'hAA, 0); send_byte(8'h00, 0);
    rand_payload(2, pl); send_frame(pl, 0, 2); wait_drain(); compare("len0");
    send_byte(8'hAA, 0); send_byte(8'h41, 0);
    rand_payload(5, pl); send_frame(pl, 0, 2); wait_drain(); compare("len65");
    rand_payload(MAXL, pl); send_frame(pl, 0, 1); wait_drain(); compare("lenmax");

    // Backpressure with a fixed ready pattern
    i_ready = 1'b0;
    send_byte(8'hAA, 0); send_byte(8'h03, 0); send_byte(bp[0], 0); send_byte(bp[1], 0); send_byte(bp[2], 0);
    send_byte(8'h03 ^ bp[0] ^ bp[1] ^ bp[2], 0);
    ntx = 0;
    for (int i = 0; i < 6; i++) begin
      i_ready = pat[i];
      @(negedge clk);
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_data", {24'd0, o_data}, {24'd0, bp[ntx]});
      if (pat[i]) ntx++;
      @(posedge clk); #1;
    end
    @(negedge clk); chk("bp_end", {31'd0, o_valid}, 32'd0);
    @(posedge clk); #1;
    compare("bp");

    // Bytes during drain are dropped, header included
    i_ready = 1'b0;
    send_byte(8'hAA, 0); send_byte(8'h02, 0); send_byte(8'hC4, 0); send_byte(8'hD5, 0);
    send_byte(8'h02 ^ 8'hC4 ^ 8'hD5, 0);
    send_byte(8'hAA, 2, 1'b0); send_byte(8'h33, 1, 1'b0); exp_ovr += 2;
    @(negedge clk); chk("ovr_hold", {22'd0, o_valid, o_last, o_data}, {22'd0, 2'b10, 8'hC4});
    @(posedge clk); #1; i_ready = 1'b1;
    wait_drain(); compare("ovr");

    // Timeout fires 400 cycles after the last strobe
    send_byte(8'hAA, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
    repeat (399) @(negedge clk);
    chk("to_early", {31'd0, o_err_timeout}, 32'd0);
    @(negedge clk); chk("to_fire", {31'd0, o_err_timeout}, 32'd1);
    @(negedge clk); chk("to_pulse", {31'd0, o_err_timeout}, 32'd0);
    exp_ev.push_back(EV_TO);
    @(posedge clk); #1;
    compare("timeout");

    // 399-cycle gap keeps the frame alive
    send_byte(8'hAA, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
    send_byte(8'h22, 398); send_byte(8'h31, 0);
    wait_drain(); compare("gap399");

    // Noise: second AA becomes LEN
    send_byte(8'h55, 0); send_byte(8'hAA, 0); send_byte(8'hAA, 0);
    send_byte(8'h01, 0); send_byte(8'h7E, 0); send_byte(8'h7F, 0);
    compare("noise");

    // Reset mid-payload and mid-drain
    send_byte(8'hAA, 0); send_byte(8'h05, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    @(negedge clk); reset_n = 1'b0; #1;
    chk("rstp_out", {17'd0, o_data, o_valid, o_last, o_pkt_ok, o_err_chk, o_err_len, o_err_timeout, o_overrun}, 32'd0);
    chk("rstp_state", 32'(dut.state), 32'(WAIT_HEADER));
    stream.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    i_ready = 1'b0;
    send_byte(8'hAA, 0); send_byte(8'h01, 0); send_byte(8'h66, 0); send_byte(8'h67, 0);
    @(negedge clk); chk("rstd_pre", {31'd0, o_valid}, 32'd1);
    reset_n = 1'b0; #1;
    chk("rstd_out", {17'd0, o_data, o_valid, o_last, o_pkt_ok, o_err_chk, o_err_len, o_err_timeout, o_overrun}, 32'd0);
    stream.delete(); exp_ev.push_back(EV_OK);
    @(posedge clk); #1 reset_n = 1'b1; i_ready = 1'b1;
    rand_payload(4, pl); send_frame(pl, 0, 1); wait_drain(); compare("after_rst");

    // Randomized mix with random backpressure
    rand_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom % 5;
      case (kind)
        0, 1: begin
          rand_payload(($urandom % 8 == 0) ? MAXL : 1 + $urandom % MAXL, pl);
          send_frame(pl, 0, 5);
        end
        2: begin rand_payload(1 + $urandom % 16, pl); send_frame(pl, 1, 5); end
        3: begin
          send_byte(8'hAA, $urandom % 6);
          send_byte(($urandom % 2) ? 8'h00 : 8'(65 + $urandom % 191), $urandom % 6);
        end
        default: begin
          for (int k = 0; k < 1 + int'($urandom % 3); k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (b == 8'hAA) b = 8'h55;
            send_byte(b, $urandom % 6);
          end
        end
      endcase
      wait_drain();
      compare("rand");
    end
    rand_rdy = 0;
    @(posedge clk); #1 i_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
